// File: rtl/div_unit.sv
// Iterative restoring divider: one quotient bit per clock, quotient to LO, remainder to HI.
// Define DIV_SIGNED_EN to add the is_signed port with signed magnitude/sign-fix/overflow logic.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
`ifdef DIV_SIGNED_EN
    input  logic             is_signed,
`endif
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dvs;
    logic             div_zero;

    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] mag1;
    logic [WIDTH-1:0] mag2;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

`ifdef DIV_SIGNED_EN
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic neg1, neg2, ovf_in;
    logic q_neg, r_neg, ovf;

    always_comb begin
        neg1   = is_signed & in1[WIDTH-1];
        neg2   = is_signed & in2[WIDTH-1];
        mag1   = neg1 ? -in1 : in1;
        mag2   = neg2 ? -in2 : in2;
        ovf_in = is_signed && (in1 == MOST_NEG) && (in2 == '1);
        // A zero divisor leaves rem = |dividend|, so the remainder sign fix restores raw in1.
        q_fix  = div_zero ? '1 : (ovf ? MOST_NEG : (q_neg ? -dvd : dvd));
        r_fix  = ovf ? '0 : (r_neg ? -rem : rem);
    end
`else
    always_comb begin
        mag1  = in1;
        mag2  = in2;
        q_fix = div_zero ? '1 : dvd;
        r_fix = rem;
    end
`endif

    // The partial remainder is WIDTH+1 bits only while shifted; after restore it always fits WIDTH.
    assign rem_sh = {rem, dvd[WIDTH-1]};
    assign trial  = rem_sh - {1'b0, dvs};

    // NOTE: every register here updates with <= so all branches see the pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            rem       <= '0;
            dvd       <= '0;
            dvs       <= '0;
            div_zero  <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef DIV_SIGNED_EN
            q_neg     <= 1'b0;
            r_neg     <= 1'b0;
            ovf       <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        state    <= CALC;
                        busy     <= 1'b1;
                        dvd      <= mag1;
                        dvs      <= mag2;
                        div_zero <= (in2 == '0);
                        rem      <= '0;
                        cnt      <= '0;
`ifdef DIV_SIGNED_EN
                        q_neg    <= neg1 ^ neg2;
                        r_neg    <= neg1;
                        ovf      <= ovf_in;
`endif
                    end
                end
                CALC: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        rem <= trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
                        dvd <= {dvd[WIDTH-2:0], ~trial[WIDTH]};
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST) state <= FIN;
                    end
                end
                FIN: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    if (!abort) begin
                        quotient  <= q_fix;
                        remainder <= r_fix;
                        done      <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed, abort, back-to-back, async reset and random divides
// compared against an arithmetic reference model built on the language's / and % operators.
module tb_div_unit;

    localparam int W = 32;
`ifdef DIV_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         abort;
    logic         sgn;
    logic [W-1:0] in1;
    logic [W-1:0] in2;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         busy;
    logic         done;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    div_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
`ifdef DIV_SIGNED_EN
        .is_signed (sgn),
`endif
        .in1       (in1),
        .in2       (in2),
        .quotient  (quotient),
        .remainder (remainder),
        .busy      (busy),
        .done      (done)
    );

    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input bit s,
                                  output logic [W-1:0] q, output logic [W-1:0] r);
        if (b == '0) begin
            q = '1;
            r = a;
        end else if (s && a == 32'h8000_0000 && b == '1) begin
            q = a;
            r = '0;
        end else if (s) begin
            q = W'($signed(a) / $signed(b));
            r = W'($signed(a) % $signed(b));
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // Drives one operation from just after an edge and waits (bounded) for done.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit s,
                         output logic [W-1:0] q, output logic [W-1:0] r,
                         output int lat, output bit busy_ok);
        in1 = a; in2 = b; sgn = s; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        in1 = $urandom; in2 = $urandom; sgn = 1'($urandom_range(0, 1));
        busy_ok = (busy === 1'b1);
        lat = 0;
        while (lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (done === 1'b1) break;
            if (busy !== 1'b1) busy_ok = 1'b0;
        end
        if (busy !== 1'b0) busy_ok = 1'b0;
        q = quotient;
        r = remainder;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; sgn = 1'b0; in1 = '0; in2 = '0;
        #12;
        n_vec++;
        if ({busy, done} !== 2'b00 || quotient !== '0 || remainder !== '0) begin
            n_err++;
            $display("FAIL reset: busy=%b done=%b q=%h r=%h, want 0 0 0 0", busy, done, quotient, remainder);
        end
        #11 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed;
        logic [W-1:0] av [4] = '{32'd100, 32'd5, 32'hFFFF_FFFF, 32'd1};
        logic [W-1:0] bv [4] = '{32'd7, 32'd0, 32'd1, 32'hFFFF_FFFF};
        logic [W-1:0] q, r, eq, er;
        int lat;
        bit bok;
        for (int i = 0; i < 4; i++) begin
            do_op(av[i], bv[i], 1'b0, q, r, lat, bok);
            model(av[i], bv[i], 1'b0, eq, er);
            n_vec++;
            if (q !== eq || r !== er || lat != 33 || !bok) begin
                n_err++;
                $display("FAIL directed %0d/%0d: q=%h r=%h lat=%0d busy_ok=%b, want q=%h r=%h lat=33 busy_ok=1",
                         av[i], bv[i], q, r, lat, bok, eq, er);
            end
        end
        @(posedge clk); #1;
        n_vec++;
        if (done !== 1'b0 || quotient !== 32'd0) begin
            n_err++;
            $display("FAIL done_pulse: done=%b q=%h, want done=0 q=00000000", done, quotient);
        end
    endtask

`ifdef DIV_SIGNED_EN
    task automatic test_signed;
        logic [W-1:0] av [4] = '{32'hFFFF_FFF9, 32'h8000_0000, 32'd7,        32'hFFFF_FFF9};
        logic [W-1:0] bv [4] = '{32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd0};
        logic [W-1:0] qx [4] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFD, 32'hFFFF_FFFF};
        logic [W-1:0] rx [4] = '{32'hFFFF_FFFF, 32'h0,         32'd1,        32'hFFFF_FFF9};
        logic [W-1:0] q, r;
        int lat;
        bit bok;
        for (int i = 0; i < 4; i++) begin
            do_op(av[i], bv[i], 1'b1, q, r, lat, bok);
            n_vec++;
            if (q !== qx[i] || r !== rx[i] || lat != 33 || !bok) begin
                n_err++;
                $display("FAIL signed %h/%h: q=%h r=%h lat=%0d, want q=%h r=%h lat=33",
                         av[i], bv[i], q, r, lat, qx[i], rx[i]);
            end
        end
    endtask
`endif

    task automatic test_abort;
        logic [W-1:0] q, r;
        int lat, n_done;
        bit bok;
        do_op(32'd100, 32'd7, 1'b0, q, r, lat, bok);
        // Abort in the 10th CALC cycle with a stray start pulse earlier on.
        in1 = 32'd1234; in2 = 32'd5; sgn = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            @(posedge clk); #1;
            start = (i == 3);
        end
        start = 1'b0; abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0 || quotient !== 32'd14 || remainder !== 32'd2) begin
            n_err++;
            $display("FAIL abort_calc: busy=%b done=%b q=%h r=%h, want 0 0 0000000e 00000002",
                     busy, done, quotient, remainder);
        end
        n_done = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done === 1'b1) n_done++;
        end
        n_vec++;
        if (n_done != 0 || quotient !== 32'd14) begin
            n_err++;
            $display("FAIL abort_nodone: dones=%0d q=%h, want 0 and 0000000e", n_done, quotient);
        end
        // Abort during the sign-fix/load cycle.
        in1 = 32'd50; in2 = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (32) begin
            @(posedge clk); #1;
        end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0 || quotient !== 32'd14 || remainder !== 32'd2) begin
            n_err++;
            $display("FAIL abort_fin: busy=%b done=%b q=%h r=%h, want 0 0 0000000e 00000002",
                     busy, done, quotient, remainder);
        end
        // A start held mid-operation must neither restart nor queue a second result.
        in1 = 32'd9; in2 = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_done = 0;
        for (int i = 1; i <= 80; i++) begin
            if (i >= 5 && i <= 9) begin
                start = 1'b1; in1 = 32'd1000; in2 = 32'd7;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            if (done === 1'b1) n_done++;
        end
        start = 1'b0;
        n_vec++;
        if (n_done != 1 || quotient !== 32'd3 || remainder !== 32'd0) begin
            n_err++;
            $display("FAIL start_while_busy: dones=%0d q=%h r=%h, want 1 00000003 00000000",
                     n_done, quotient, remainder);
        end
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] q, r;
        int lat;
        bit bok;
        do_op(32'd100, 32'd7, 1'b0, q, r, lat, bok);
        n_vec++;
        if (q !== 32'd14 || r !== 32'd2 || lat != 33 || !bok) begin
            n_err++;
            $display("FAIL b2b_first: q=%h r=%h lat=%0d, want 0000000e 00000002 33", q, r, lat);
        end
        // do_op returns in the done cycle, so this start lands while done is high.
        do_op(32'd9, 32'd3, 1'b0, q, r, lat, bok);
        n_vec++;
        if (q !== 32'd3 || r !== 32'd0 || lat != 33 || !bok) begin
            n_err++;
            $display("FAIL b2b_second: q=%h r=%h lat=%0d busy_ok=%b, want 00000003 00000000 33 1",
                     q, r, lat, bok);
        end
    endtask

    task automatic test_async_reset;
        logic [W-1:0] q, r;
        int lat;
        bit bok;
        do_op(32'd100, 32'd7, 1'b0, q, r, lat, bok);
        in1 = 32'd1000; in2 = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #4 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({busy, done} !== 2'b00 || quotient !== '0 || remainder !== '0) begin
            n_err++;
            $display("FAIL async_reset: busy=%b done=%b q=%h r=%h, want 0 0 0 0", busy, done, quotient, remainder);
        end
        #10 rst_n = 1'b1;
        @(posedge clk); #1;
        do_op(32'd77, 32'd5, 1'b0, q, r, lat, bok);
        n_vec++;
        if (q !== 32'd15 || r !== 32'd2 || lat != 33 || !bok) begin
            n_err++;
            $display("FAIL after_reset: q=%h r=%h lat=%0d, want 0000000f 00000002 33", q, r, lat);
        end
    endtask

    task automatic test_random;
        logic [W-1:0] a, b, q, r, eq, er;
        bit s, bok;
        int lat;
        for (int i = 0; i < 30; i++) begin
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            s = SIGNED_EN ? 1'($urandom_range(0, 1)) : 1'b0;
            case ($urandom_range(0, 5))
                0: b = '0;
                1: b = W'($urandom_range(1, 15));
                2: begin a = 32'h8000_0000; b = '1; end
                default: ;
            endcase
            do_op(a, b, s, q, r, lat, bok);
            model(a, b, s, eq, er);
            n_vec++;
            if (q !== eq || r !== er || lat != 33 || !bok) begin
                n_err++;
                $display("FAIL random %h/%h s=%b: q=%h r=%h lat=%0d busy_ok=%b, want q=%h r=%h lat=33",
                         a, b, s, q, r, lat, bok, eq, er);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
`ifdef DIV_SIGNED_EN
        test_signed();
`endif
        test_abort();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
